// File: rtl/llc_pipe_scheduler.sv
// LLC front-end issue scheduler: arbitrates rsp/rst_tb/req/dma and tracks in-flight sets in order.
// Optional `LLC_SCHED_STATS_EN adds the hazard_stalls saturating counter output.
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif
module llc_pipe_scheduler #(
  parameter int unsigned SET_BITS     = `LLC_SET_BITS,
  parameter int unsigned NUM_INFLIGHT = 4,
  parameter int unsigned STARVE_MAX   = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rsp_valid,
  input  logic [SET_BITS-1:0]           rsp_set,
  output logic                          rsp_ready,
  input  logic                          rst_tb_valid,
  output logic                          rst_tb_ready,
  input  logic                          req_valid,
  input  logic [SET_BITS-1:0]           req_set,
  output logic                          req_ready,
  input  logic                          dma_valid,
  input  logic [SET_BITS-1:0]           dma_set,
  output logic                          dma_ready,
  input  logic                          issue_ready,
  output logic                          issue_valid,
  output logic [1:0]                    issue_src,
  output logic [SET_BITS-1:0]           issue_set,
  input  logic                          retire_valid,
  output logic [$clog2(NUM_INFLIGHT):0] inflight_cnt,
  output logic                          retire_err
`ifdef LLC_SCHED_STATS_EN
  ,
  output logic [15:0]                   hazard_stalls
`endif
);
  localparam int unsigned PW = $clog2(NUM_INFLIGHT);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {RR_REQ, RR_DMA} rr_e;
  typedef enum logic [1:0] {SRC_RSP = 2'd0, SRC_RST = 2'd1, SRC_REQ = 2'd2, SRC_DMA = 2'd3} src_e;

  logic [SET_BITS-1:0]     tbl_q [NUM_INFLIGHT];
  logic [NUM_INFLIGHT-1:0] vld_q;
  logic [PW-1:0]           head_q, tail_q;
  logic [CW-1:0]           cnt_q;
  logic [3:0]              starve_q;
  rr_e                     rr_q;
  logic                    err_q;

  logic req_hz, dma_hz, req_elig, dma_elig, rst_elig, gate, starving, pick_dma;
  logic gnt, push, pop;
  src_e src;

  always_comb begin
    req_hz = 1'b0;
    dma_hz = 1'b0;
    for (int unsigned i = 0; i < NUM_INFLIGHT; i++) begin
      if (vld_q[i] && (tbl_q[i] == req_set)) req_hz = 1'b1;
      if (vld_q[i] && (tbl_q[i] == dma_set)) dma_hz = 1'b1;
    end
  end

  assign req_elig = req_valid && !req_hz && !rst_tb_valid;
  assign dma_elig = dma_valid && !dma_hz && !rst_tb_valid;
  assign rst_elig = rst_tb_valid && (cnt_q == '0);
  // Raw rst in the gate keeps every grant output low while reset is asserted.
  assign gate     = rst && issue_ready && (cnt_q < CW'(NUM_INFLIGHT));
  assign starving = (starve_q == STARVE_MAX[3:0]) && (req_elig || dma_elig);
  assign pick_dma = dma_elig && (!req_elig || (rr_q == RR_DMA));

  always_comb begin
    gnt = 1'b0;
    src = SRC_RSP;
    if (gate) begin
      if (starving) begin
        gnt = 1'b1;
        src = pick_dma ? SRC_DMA : SRC_REQ;
      end else if (rsp_valid) begin
        gnt = 1'b1;
        src = SRC_RSP;
      end else if (rst_elig) begin
        gnt = 1'b1;
        src = SRC_RST;
      end else if (req_elig || dma_elig) begin
        gnt = 1'b1;
        src = pick_dma ? SRC_DMA : SRC_REQ;
      end
    end
  end

  always_comb begin
    issue_set = '0;
    if (gnt) begin
      case (src)
        SRC_RSP: issue_set = rsp_set;
        SRC_REQ: issue_set = req_set;
        SRC_DMA: issue_set = dma_set;
        default: issue_set = '0;
      endcase
    end
  end

  assign issue_valid  = gnt;
  assign issue_src    = src;
  assign rsp_ready    = gnt && (src == SRC_RSP);
  assign rst_tb_ready = gnt && (src == SRC_RST);
  assign req_ready    = gnt && (src == SRC_REQ);
  assign dma_ready    = gnt && (src == SRC_DMA);
  assign inflight_cnt = cnt_q;
  assign retire_err   = err_q;

  assign push = gnt;
  assign pop  = retire_valid && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      rr_q     <= RR_REQ;
      err_q    <= 1'b0;
    end else begin
      // push and pop never share a slot: push needs count<N, pop needs count>0
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (gnt && ((src == SRC_REQ) || (src == SRC_DMA))) begin
        starve_q <= '0;
        rr_q     <= (src == SRC_REQ) ? RR_DMA : RR_REQ;
      end else if (gnt && (src == SRC_RSP) && (req_elig || dma_elig) &&
                   (starve_q != STARVE_MAX[3:0])) begin
        starve_q <= starve_q + 1'b1;
      end
      if (retire_valid && (cnt_q == '0)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tbl_q[tail_q] <= issue_set;
  end

`ifdef LLC_SCHED_STATS_EN
  logic [15:0] stalls_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stalls_q <= '0;
    end else if (((req_valid && req_hz) || (dma_valid && dma_hz)) && !rst_tb_valid &&
                 (stalls_q != '1)) begin
      stalls_q <= stalls_q + 1'b1;
    end
  end
  assign hazard_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_llc_pipe_scheduler.sv
// Bench for llc_pipe_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_llc_pipe_scheduler;
  localparam int SB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          rsp_valid = 1'b0, rst_tb_valid = 1'b0, req_valid = 1'b0, dma_valid = 1'b0;
  logic          issue_ready = 1'b0, retire_valid = 1'b0;
  logic [SB-1:0] rsp_set = '0, req_set = '0, dma_set = '0;
  logic          rsp_ready, rst_tb_ready, req_ready, dma_ready, issue_valid, retire_err;
  logic [1:0]    issue_src;
  logic [SB-1:0] issue_set;
  logic [2:0]    inflight_cnt;
`ifdef LLC_SCHED_STATS_EN
  logic [15:0]   hazard_stalls;
`endif

  llc_pipe_scheduler #(.SET_BITS(SB), .NUM_INFLIGHT(4), .STARVE_MAX(15)) dut (
    .clk(clk), .rst(rst),
    .rsp_valid(rsp_valid), .rsp_set(rsp_set), .rsp_ready(rsp_ready),
    .rst_tb_valid(rst_tb_valid), .rst_tb_ready(rst_tb_ready),
    .req_valid(req_valid), .req_set(req_set), .req_ready(req_ready),
    .dma_valid(dma_valid), .dma_set(dma_set), .dma_ready(dma_ready),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_src(issue_src),
    .issue_set(issue_set), .retire_valid(retire_valid), .inflight_cnt(inflight_cnt),
    .retire_err(retire_err)
`ifdef LLC_SCHED_STATS_EN
    , .hazard_stalls(hazard_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-order queue of in-flight sets, starvation count, rr preference, sticky error.
  logic [SB-1:0] mq[$];
  int            mstarve;
  bit            mrr_dma;
  bit            merr;

  logic          o_valid, o_err;
  logic [1:0]    o_src;
  logic [SB-1:0] o_set;
  logic [2:0]    o_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rv, input logic [SB-1:0] rs, input bit tv,
                      input bit qv, input logic [SB-1:0] qs,
                      input bit dv, input logic [SB-1:0] ds,
                      input bit ir, input bit ret);
    bit hr, hd, er, ed, ers, gate;
    int src;
    logic [SB-1:0] es;
    rsp_valid = rv; rsp_set = rs; rst_tb_valid = tv;
    req_valid = qv; req_set = qs; dma_valid = dv; dma_set = ds;
    issue_ready = ir; retire_valid = ret;
    hr = 0; hd = 0;
    foreach (mq[i]) begin
      if (mq[i] == qs) hr = 1;
      if (mq[i] == ds) hd = 1;
    end
    er   = qv && !hr && !tv;
    ed   = dv && !hd && !tv;
    ers  = tv && (mq.size() == 0);
    gate = ir && (mq.size() < 4);
    src  = -1;
    if (gate) begin
      if ((er || ed) && mstarve == 15) src = (er && ed) ? (mrr_dma ? 3 : 2) : (er ? 2 : 3);
      else if (rv)                     src = 0;
      else if (ers)                    src = 1;
      else if (er || ed)               src = (er && ed) ? (mrr_dma ? 3 : 2) : (er ? 2 : 3);
    end
    es = (src == 0) ? rs : (src == 2) ? qs : (src == 3) ? ds : '0;
    #3;
    o_valid = issue_valid; o_src = issue_src; o_set = issue_set;
    o_cnt = inflight_cnt; o_err = retire_err;
    chk("issue_valid", 32'(issue_valid), 32'(src >= 0));
    chk("issue_src", 32'(issue_src), (src < 0) ? 0 : src);
    chk("issue_set", 32'(issue_set), 32'(es));
    chk("rsp_ready", 32'(rsp_ready), 32'(src == 0));
    chk("rst_tb_ready", 32'(rst_tb_ready), 32'(src == 1));
    chk("req_ready", 32'(req_ready), 32'(src == 2));
    chk("dma_ready", 32'(dma_ready), 32'(src == 3));
    chk("inflight_cnt", 32'(inflight_cnt), mq.size());
    chk("retire_err", 32'(retire_err), 32'(merr));
    @(posedge clk);
    #1;
    if (ret) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else merr = 1;
    end
    if (src >= 0) mq.push_back(es);
    if (src == 0 && (er || ed) && mstarve < 15) mstarve++;
    if (src == 2 || src == 3) begin
      mstarve = 0;
      mrr_dma = (src == 2);
    end
  endtask

  task automatic idle(input bit ret);
    step(0, '0, 0, 0, '0, 0, '0, 1, ret);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    rsp_valid = 1; rsp_set = 8'h09; req_valid = 1; req_set = 8'h03;
    dma_valid = 0; rst_tb_valid = 0; issue_ready = 1; retire_valid = 0;
    #1;
    chk("rst_rsp_ready", 32'(rsp_ready), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_inflight", 32'(inflight_cnt), 0);
    chk("rst_err", 32'(retire_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rsp_valid = 0; req_valid = 0;
    mq.delete(); mstarve = 0; mrr_dma = 0; merr = 0;
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0] prev_src;
    #1;
    do_reset();

    step(1, 8'd5, 0, 0, '0, 0, '0, 1, 0);
    chk("first_valid", 32'(o_valid), 1);
    chk("first_src", 32'(o_src), 0);
    chk("first_set", 32'(o_set), 5);
    idle(1);
    chk("first_cnt", 32'(o_cnt), 1);

    step(0, '0, 0, 1, 8'h12, 0, '0, 1, 0);
    chk("haz_first", 32'(o_src), 2);
    step(0, '0, 0, 1, 8'h12, 0, '0, 1, 0);
    chk("haz_block", 32'(o_valid), 0);
    step(0, '0, 0, 1, 8'h12, 0, '0, 1, 1);
    chk("haz_retiring", 32'(o_valid), 0);
    step(0, '0, 0, 1, 8'h12, 0, '0, 1, 0);
    chk("haz_after_valid", 32'(o_valid), 1);
    chk("haz_after_src", 32'(o_src), 2);
    idle(1);

    prev_src = 2'd0;
    for (int k = 0; k < 4; k++) begin
      step(0, '0, 0, 1, 8'(32'h20 + k), 1, 8'(32'h30 + k), 1, k > 0);
      chk("rr_valid", 32'(o_valid), 1);
      if (k > 0) chk("rr_alternate", 32'(o_src), 32'(prev_src ^ 2'd1));
      prev_src = o_src;
    end
    idle(1);

    for (int k = 0; k < 16; k++) begin
      step(1, 8'(32'h40 + k), 0, 1, 8'h7F, 0, '0, 1, k > 0);
      chk("starve_src", 32'(o_src), (k < 15) ? 0 : 2);
    end
    step(1, 8'h50, 0, 1, 8'h7E, 0, '0, 1, 1);
    chk("starve_cleared", 32'(o_src), 0);
    idle(1);

    step(0, '0, 0, 1, 8'h60, 0, '0, 1, 0);
    step(0, '0, 0, 0, '0, 1, 8'h61, 1, 0);
    step(0, '0, 1, 1, 8'h62, 1, 8'h63, 1, 0);
    chk("drain_block0", 32'(o_valid), 0);
    step(0, '0, 1, 1, 8'h62, 1, 8'h63, 1, 1);
    chk("drain_block1", 32'(o_valid), 0);
    step(0, '0, 1, 1, 8'h62, 1, 8'h63, 1, 1);
    chk("drain_block2", 32'(o_valid), 0);
    step(0, '0, 1, 1, 8'h62, 1, 8'h63, 1, 0);
    chk("drain_rst_src", 32'(o_src), 1);
    chk("drain_rst_set", 32'(o_set), 0);
    idle(1);

    for (int k = 0; k < 4; k++) step(0, '0, 0, 1, 8'(32'h70 + k), 0, '0, 1, 0);
    step(0, '0, 0, 1, 8'h74, 0, '0, 1, 1);
    chk("full_block", 32'(o_valid), 0);
    chk("full_cnt", 32'(o_cnt), 4);
    step(0, '0, 0, 1, 8'h74, 0, '0, 1, 0);
    chk("full_next", 32'(o_valid), 1);
    for (int k = 0; k < 4; k++) idle(1);
    idle(1);
    idle(0);
    chk("retire_err_set", 32'(o_err), 1);

    for (int n = 0; n < 1200; n++) begin
      step($urandom_range(0, 2) == 0, 8'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)),
           $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
    end

    step(0, '0, 0, 1, 8'h10, 0, '0, 1, 0);
    do_reset();
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
